// File: rtl/alpaca_multadd_pkg.sv
// Shared fixed-point types and pipeline constants for the ALPACA multiply-add cell.
// Operands are Q1.15; the product and the final sum carry 30 fractional bits.
package alpaca_multadd_pkg;

   localparam int WIDTH      = 16;
   localparam int FRAC_WIDTH = 15;
   localparam int MULT_LAT   = 4;
   localparam int LAT        = MULT_LAT + 1;
   localparam int PERIOD     = 10;

   typedef logic signed [WIDTH-1:0]   sample_t;
   typedef logic signed [2*WIDTH-1:0] prod_t;
   typedef logic signed [2*WIDTH:0]   mac_t;

endpackage

// File: rtl/alpaca_multadd_mult.sv
// Pipelined signed WIDTH x WIDTH multiplier, DSP48-style: A/B input registers,
// then an M register and MULT_LAT-2 further product registers.
module alpaca_mult
   import alpaca_multadd_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic signed [WIDTH-1:0]   i_a,
   input  logic signed [WIDTH-1:0]   i_b,
   output logic signed [2*WIDTH-1:0] o_p
);

   sample_t r_a;
   sample_t r_b;
   prod_t   r_p [MULT_LAT-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a <= '0;
         r_b <= '0;
         // NOTE: the product stages are reset element by element so an
         // in-flight result can never reappear after a mid-stream reset.
         for (int i = 0; i < MULT_LAT-1; i++) r_p[i] <= '0;
      end else begin
         r_a    <= i_a;
         r_b    <= i_b;
         r_p[0] <= prod_t'(r_a) * prod_t'(r_b);
         for (int i = 1; i < MULT_LAT-1; i++) r_p[i] <= r_p[i-1];
      end
   end

   assign o_p = r_p[MULT_LAT-2];

endmodule

// File: rtl/alpaca_multadd.sv
// Full-precision signed multiply-add, dout = a*b + c, one operand set per cycle.
// The addend rides its own delay line so it meets the product of the same cycle.
module alpaca_multadd
   import alpaca_multadd_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] i_a_data,
   input  logic signed [WIDTH-1:0] i_b_data,
   input  logic signed [WIDTH-1:0] i_c_data,
   output logic signed [2*WIDTH:0] o_dout_data
);

   prod_t   w_p;
   sample_t r_c [MULT_LAT];
   mac_t    r_dout;

   alpaca_mult u_mult (
      .clk (clk),
      .rst (rst),
      .i_a (i_a_data),
      .i_b (i_b_data),
      .o_p (w_p)
   );

   // c is sign-extended before the shift so its binary point lands on the product's.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MULT_LAT; i++) r_c[i] <= '0;
         r_dout <= '0;
      end else begin
         r_c[0] <= i_c_data;
         for (int i = 1; i < MULT_LAT; i++) r_c[i] <= r_c[i-1];
         r_dout <= mac_t'(w_p) + (mac_t'(r_c[MULT_LAT-1]) <<< FRAC_WIDTH);
      end
   end

   assign o_dout_data = r_dout;

endmodule

// File: tb/tb_alpaca_multadd.sv
// Self-checking bench for alpaca_multadd: directed fixed-point cases plus a
// randomized stream checked against an arithmetic reference with a latency queue.
module tb_alpaca_multadd;
   import alpaca_multadd_pkg::*;

   logic    clk;
   logic    rst;
   sample_t a_d;
   sample_t b_d;
   sample_t c_d;
   mac_t    dout;

   int checks;
   int errors;

   mac_t exp_q [$];

   alpaca_multadd dut (
      .clk         (clk),
      .rst         (rst),
      .i_a_data    (a_d),
      .i_b_data    (b_d),
      .i_c_data    (c_d),
      .o_dout_data (dout)
   );

   initial clk = 1'b0;
   always #(PERIOD/2) clk = ~clk;

   // Exact value of a*b + c in units of 2^-30, using wide plain integers.
   function automatic mac_t golden(input sample_t a, input sample_t b, input sample_t c);
      longint r;
      r = longint'(a) * longint'(b) + longint'(c) * (longint'(1) << FRAC_WIDTH);
      return mac_t'(r);
   endfunction

   // After reset the output shows zeros until the first post-reset operands emerge.
   task automatic reset_model();
      exp_q.delete();
      repeat (LAT-1) exp_q.push_back('0);
   endtask

   task automatic step(input sample_t a, input sample_t b, input sample_t c, output mac_t exp);
      a_d = a;
      b_d = b;
      c_d = c;
      @(posedge clk);
      #1;
      if (rst) begin
         reset_model();
         exp = '0;
      end else begin
         exp_q.push_back(golden(a, b, c));
         exp = exp_q.pop_front();
      end
   endtask

   function automatic sample_t rnd();
      return sample_t'($urandom_range(0, 65535));
   endfunction

   task automatic test_reset();
      mac_t exp;
      mac_t req;
      rst = 1'b1;
      reset_model();
      for (int i = 0; i < 3; i++) begin
         step(16'sd1, 16'sd1, 16'sd1, exp);
         checks++;
         if (dout !== '0) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: got %h want 0", i, dout);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (dout !== '0) begin
         errors++;
         $display("FAIL reset_release: got %h want 0", dout);
      end
      for (int i = 1; i <= 8; i++) begin
         step(sample_t'(i), sample_t'(i), sample_t'(i), exp);
         req = (i <= LAT-1) ? mac_t'(0) : exp;
         checks++;
         if (dout !== req) begin
            errors++;
            $display("FAIL reset_flush step %0d: got %h want %h", i, dout, req);
         end
      end
   endtask

   task automatic test_basic();
      mac_t exp;
      step(16'sd1, 16'sd1, 16'sd1, exp);
      for (int i = 0; i < LAT-1; i++) step(16'sd0, 16'sd0, 16'sd0, exp);
      checks++;
      if (dout !== 33'sh0_0000_8001) begin
         errors++;
         $display("FAIL basic_fixed_point: got %h want 000008001", dout);
      end
      checks++;
      if (dout !== exp) begin
         errors++;
         $display("FAIL basic_model: got %h want %h", dout, exp);
      end
   endtask

   task automatic test_back_to_back();
      mac_t    exp;
      longint  n;
      mac_t    req;
      for (int s = 0; s < 14; s++) begin
         step(sample_t'(s+1), sample_t'(s+1), sample_t'(s+1), exp);
         checks++;
         if (dout !== exp) begin
            errors++;
            $display("FAIL stream_model step %0d: got %h want %h", s, dout, exp);
         end
         if (s >= LAT-1) begin
            n   = longint'(s - (LAT-1) + 1);
            req = mac_t'(n * n + n * 32768);
            checks++;
            if (dout !== req) begin
               errors++;
               $display("FAIL stream_ramp n=%0d: got %h want %h", n, dout, req);
            end
         end
      end
   endtask

   task automatic test_extremes();
      mac_t exp;
      mac_t req [3];
      req[0] = 33'sh0_7FFF_8000;
      req[1] = '0;
      req[2] = '0;
      step(-16'sd32768, -16'sd32768,  16'sd32767, exp);
      step(-16'sd32768, -16'sd32768, -16'sd32768, exp);
      step( 16'sd32767, -16'sd32768,  16'sd32767, exp);
      step(16'sd0, 16'sd0, 16'sd0, exp);
      for (int i = 0; i < 3; i++) begin
         step(16'sd0, 16'sd0, 16'sd0, exp);
         checks++;
         if (dout !== req[i] || dout !== exp) begin
            errors++;
            $display("FAIL extreme_%0d: got %h want %h (model %h)", i, dout, req[i], exp);
         end
      end
   endtask

   task automatic test_async_reset();
      mac_t exp;
      for (int i = 0; i < 6; i++) step(16'sd1000 + sample_t'(i), 16'sd3, 16'sd7, exp);
      @(negedge clk);
      rst = 1'b1;
      reset_model();
      #1;
      checks++;
      if (dout !== '0) begin
         errors++;
         $display("FAIL async_assert: got %h want 0 before any edge", dout);
      end
      for (int i = 0; i < 2; i++) begin
         step(rnd(), rnd(), rnd(), exp);
         checks++;
         if (dout !== '0) begin
            errors++;
            $display("FAIL async_hold cycle %0d: got %h want 0", i, dout);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (dout !== '0) begin
         errors++;
         $display("FAIL async_release: got %h want 0", dout);
      end
      for (int i = 0; i < 10; i++) begin
         step(rnd(), rnd(), rnd(), exp);
         checks++;
         if (dout !== exp) begin
            errors++;
            $display("FAIL async_restart step %0d: got %h want %h", i, dout, exp);
         end
      end
   endtask

   task automatic test_random();
      mac_t exp;
      for (int i = 0; i < 400; i++) begin
         step(rnd(), rnd(), rnd(), exp);
         checks++;
         if (dout !== exp) begin
            errors++;
            $display("FAIL random cycle %0d: got %h want %h", i, dout, exp);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      a_d    = '0;
      b_d    = '0;
      c_d    = '0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_extremes();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
